// File: rtl/mem_stream_reader_pkg.sv
// Shared constants, state encoding and types for the memory stream reader.
package mem_stream_reader_pkg;

    localparam int unsigned AW = 9;   // memory address width, depth 2^AW
    localparam int unsigned DW = 20;  // data word width
    localparam int unsigned LW = 10;  // burst length width, holds 2^AW

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [LW-1:0] len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output buffer payload: stream word plus its end-of-burst marker.
    typedef struct packed {
        logic  last;
        data_t data;
    } beat_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Command and output-stream handshake bundle of the memory stream reader.
// The reader is the slave: it accepts commands and sources the stream.
interface mem_stream_reader_if;
    import mem_stream_reader_pkg::*;

    logic  cmd_valid;
    logic  cmd_ready;
    addr_t cmd_addr;
    len_t  cmd_len;

    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    logic  out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/mem_stream_reader_fifo2.sv
// Two-entry registered FIFO holding {last, data} beats; head is read
// straight from storage, so a pushed beat is visible the cycle after.
module fifo2
    import mem_stream_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output beat_t      dout,
    output logic [1:0] count,
    output logic       empty
);

    beat_t      mem_q [2];
    beat_t      mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       full;
    logic       wr_en;
    logic       rd_en;

    // Pointer/occupancy update; a push into a full FIFO is only taken when a pop frees a slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full     = (cnt_q == 2'd2);
        rd_en    = pop && (cnt_q != 2'd0);
        wr_en    = push && (!full || rd_en);
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(wr_en) - 2'(rd_en);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// Burst read controller for the 512 x 20 two-port memory: takes a
// (start address, length) command, reads consecutive words through the
// registered-read port and presents them as a valid/ready stream with a
// last marker. Optional stall counter: define MEM_STREAM_READER_PERF_EN.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    mem_stream_reader_if.slave  bus,
    output addr_t               ra,
    input  data_t               q,
    output logic                busy,
    output logic                done,
    output logic [15:0]         stall_cnt
);

    state_t state_q, state_d;
    addr_t  addr_q, addr_d;
    len_t   issue_rem_q, issue_rem_d;
    len_t   out_rem_q, out_rem_d;
    logic   inflight_q, inflight_d;
    logic   cmd_ready_q, cmd_ready_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    beat_t      fifo_head;
    beat_t      push_beat;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       accept;
    logic       issue;
    logic [2:0] credit;

    // Handshake decode and credit check. ra is the address counter itself, so
    // a read is issued in the same cycle the decision is made and at most one
    // read is in flight; with that, a 2-entry buffer sustains one word per cycle.
    always_comb begin
        pop            = !fifo_empty && bus.out_ready;
        push           = inflight_q;
        push_beat.last = (out_rem_q == len_t'(1));
        push_beat.data = q;
        credit         = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        accept         = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
        issue          = (state_q == RUN) && (issue_rem_q != '0) && (credit < 3'd2);
    end

    // Next-state, address/length counters and registered status outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        inflight_d  = issue;
        done_d      = 1'b0;
        if (push) begin
            out_rem_d = out_rem_q - len_t'(1);
        end
        if (issue) begin
            addr_d      = addr_q + addr_t'(1);
            issue_rem_d = issue_rem_q - len_t'(1);
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = bus.cmd_addr;
                    issue_rem_d = bus.cmd_len;
                    out_rem_d   = bus.cmd_len;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && (issue_rem_q == len_t'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Controller state register; reset aborts any burst and drops in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            out_rem_q   <= '0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            inflight_q  <= inflight_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    fifo2 u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .din   (push_beat),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

`ifdef MEM_STREAM_READER_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles a word waits on the consumer; cleared per command.
    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if ((state_q != IDLE) && !fifo_empty && !bus.out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign ra            = addr_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head.data;
    assign bus.out_last  = fifo_head.last;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural 512 x 20 memory
// (registered read, old data on read-during-write) preloaded with 0x0A000+i.
module tb_mem_stream_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stream_reader_if bus ();

    logic [8:0]  ra;
    logic [19:0] q;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    mem_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ra        (ra),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    // Memory model
    logic [19:0] mem [512];
    logic        we;
    logic [8:0]  wa;
    logic [19:0] wd;
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
        q <= mem[ra];
    end

    int checks = 0;
    int errors = 0;

    // Burst observation results
    logic [19:0] got_data [512];
    logic        got_last [512];
    logic [8:0]  ra_hist  [16];
    logic [31:0] ready_pat;
    int n_got, n_valid, first_k, last_valid_k, done_k, done_cnt;
    int stab_err, stall_model, last_cnt, last_idx, busy_rdy, timeout;

    task automatic preload();
        for (int i = 0; i < 512; i++) begin
            we = 1'b1;
            wa = 9'(i);
            wd = 20'h0A000 + 20'(i);
            @(posedge clk); #1;
        end
        we = 1'b0;
    endtask

    // Issue one command and watch the stream until a few cycles after done.
    // k counts cycles after the accept edge. mode 0: out_ready=1, else ready_pat.
    task automatic do_burst(input int a, input int len, input int mode, input int max_k);
        int k;
        int after;
        logic prev_stall;
        logic [19:0] prev_data;
        n_got = 0; n_valid = 0; first_k = -1; last_valid_k = -1; done_k = -1; done_cnt = 0;
        stab_err = 0; stall_model = 0; last_cnt = 0; last_idx = -1; busy_rdy = 0; timeout = 0;
        prev_stall = 1'b0; prev_data = '0; after = 0;
        for (int i = 0; i < 16; i++) ra_hist[i] = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 9'(a);
        bus.cmd_len   = 10'(len);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 1;
        while (1) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ready_pat[k % 32];
            if (k < 16) ra_hist[k] = ra;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_err++;
            if (busy && bus.cmd_ready) busy_rdy++;
            if (bus.out_valid) begin
                n_valid++;
                if (first_k < 0) first_k = k;
                last_valid_k = k;
            end
            if (bus.out_valid && !bus.out_ready) stall_model++;
            if (bus.out_valid && bus.out_ready && n_got < 512) begin
                got_data[n_got] = bus.out_data;
                got_last[n_got] = bus.out_last;
                if (bus.out_last) begin
                    last_cnt++;
                    last_idx = n_got;
                end
                n_got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0) after++;
            if (after > 3) break;
            if (k >= max_k) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.out_valid, bus.out_last, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.cmd_ready, bus.out_valid, bus.out_last, busy, done});
        end
        checks++;
        if (ra !== 9'd0) begin errors++; $display("FAIL reset_ra: got %0h expected 0", ra); end
        checks++;
        if (bus.out_data !== 20'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.out_data); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_basic();
        do_burst(5, 4, 0, 40);
        checks++;
        if (timeout != 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
        checks++;
        if (n_got != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== 20'h0A005 + 20'(i)) begin
                errors++; $display("FAIL basic_word%0d: got %0h expected %0h", i, got_data[i], 20'h0A005 + 20'(i));
            end
        end
        checks++;
        if (first_k != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", first_k); end
        checks++;
        if (last_valid_k - first_k + 1 != 4) begin
            errors++; $display("FAIL basic_consecutive: got span %0d expected 4", last_valid_k - first_k + 1);
        end
        checks++;
        if (last_cnt != 1 || last_idx != 3) begin
            errors++; $display("FAIL basic_last: got count %0d idx %0d expected 1 idx 3", last_cnt, last_idx);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
        checks++;
        if (busy_rdy != 0) begin errors++; $display("FAIL basic_ready_busy: got %0d expected 0", busy_rdy); end
        checks++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL basic_idle: got ready,busy=%b expected 10", {bus.cmd_ready, busy});
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_d;
        logic [8:0]  exp_a;
        do_burst(510, 4, 0, 40);
        checks++;
        if (n_got != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 20'h0A000 + 20'((510 + i) % 512);
            exp_a = 9'((510 + i) % 512);
            checks++;
            if (got_data[i] !== exp_d) begin
                errors++; $display("FAIL wrap_word%0d: got %0h expected %0h", i, got_data[i], exp_d);
            end
            checks++;
            if (ra_hist[i + 1] !== exp_a) begin
                errors++; $display("FAIL wrap_ra%0d: got %0d expected %0d", i, ra_hist[i + 1], exp_a);
            end
        end
        checks++;
        if (ra !== 9'd2) begin errors++; $display("FAIL wrap_ra_final: got %0d expected 2", ra); end
    endtask

    task automatic test_backpressure();
        ready_pat = 32'b1011_0100_1110_0101_1001_0110_1100_1001;
        do_burst(0, 8, 1, 200);
        checks++;
        if (timeout != 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timeout); end
        checks++;
        if (n_got != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", n_got); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[i] !== 20'h0A000 + 20'(i)) begin
                errors++; $display("FAIL bp_word%0d: got %0h expected %0h", i, got_data[i], 20'h0A000 + 20'(i));
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err); end
        checks++;
        if (last_cnt != 1 || last_idx != 7) begin
            errors++; $display("FAIL bp_last: got count %0d idx %0d expected 1 idx 7", last_cnt, last_idx);
        end
        checks++;
`ifdef MEM_STREAM_READER_PERF_EN
        if (stall_cnt !== 16'(stall_model)) begin
            errors++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, stall_model);
        end
`else
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    endtask

    task automatic test_zero_len();
        do_burst(7, 0, 0, 20);
        checks++;
        if (timeout != 0) begin errors++; $display("FAIL zero_timeout: got %0d expected 0", timeout); end
        checks++;
        if (n_valid != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles expected 0", n_valid); end
        checks++;
        if (done_k != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_k); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL zero_idle: got ready,busy=%b expected 10", {bus.cmd_ready, busy});
        end
    endtask

    task automatic test_full_wrap();
        logic [19:0] exp_d;
        do_burst(100, 512, 0, 700);
        checks++;
        if (timeout != 0) begin errors++; $display("FAIL full_timeout: got %0d expected 0", timeout); end
        checks++;
        if (n_got != 512) begin errors++; $display("FAIL full_count: got %0d expected 512", n_got); end
        for (int i = 0; i < 512; i++) begin
            exp_d = 20'h0A000 + 20'((100 + i) % 512);
            checks++;
            if (got_data[i] !== exp_d) begin
                errors++; $display("FAIL full_word%0d: got %0h expected %0h", i, got_data[i], exp_d);
            end
        end
        checks++;
        if (got_data[511] !== 20'h0A063) begin errors++; $display("FAIL full_final: got %0h expected a063", got_data[511]); end
        checks++;
        if (last_cnt != 1 || last_idx != 511) begin
            errors++; $display("FAIL full_last: got count %0d idx %0d expected 1 idx 511", last_cnt, last_idx);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL full_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int k;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 9'd0;
        bus.cmd_len   = 10'd10;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cnt = 0;
        k = 0;
        while (cnt < 3 && k < 20) begin
            if (bus.out_valid && bus.out_ready) cnt++;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (cnt != 3) begin errors++; $display("FAIL mid_progress: got %0d words expected 3", cnt); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.out_valid, bus.out_last, busy, done} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_flags: got %b expected 00000", {bus.cmd_ready, bus.out_valid, bus.out_last, busy, done});
        end
        checks++;
        if (ra !== 9'd0) begin errors++; $display("FAIL mid_reset_ra: got %0d expected 0", ra); end
        checks++;
        if (bus.out_data !== 20'h0) begin errors++; $display("FAIL mid_reset_data: got %0h expected 0", bus.out_data); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_stall: got %0d expected 0", stall_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %b expected 1", bus.cmd_ready); end
        do_burst(0, 2, 0, 30);
        checks++;
        if (n_got != 2) begin errors++; $display("FAIL mid_new_count: got %0d expected 2", n_got); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_data[i] !== 20'h0A000 + 20'(i)) begin
                errors++; $display("FAIL mid_new_word%0d: got %0h expected %0h", i, got_data[i], 20'h0A000 + 20'(i));
            end
        end
        checks++;
        if (last_cnt != 1 || last_idx != 1) begin
            errors++; $display("FAIL mid_new_last: got count %0d idx %0d expected 1 idx 1", last_cnt, last_idx);
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side controller for the 512 x 20-bit two-port memory. It drives the memory's read address port and consumes its registered read data (q valid one cycle after ra).
- Accepts a burst command (start address, length), reads consecutive words and presents them as a valid/ready stream with a last marker.
- Sits between the memory and any downstream consumer that applies backpressure.

Parameters:
- AW, 9, memory address width (depth 2^AW).
- DW, 20, data word width.
- LW, 10, burst length width; must hold the value 2^AW.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  burst command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_addr  input  AW  first word address.
- cmd_len  input  LW  word count; valid range is 0..2^AW.
- ra  output  AW  memory read address.
- q  input  DW  memory read data, valid the cycle after the address was issued.
- out_valid  output  1  stream word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DW  stream word.
- out_last  output  1  marks the final word of the burst.
- busy  output  1  a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.
- stall_cnt  output  16  backpressure counter (see Optional Feature).

Behaviour:
- Reset values: cmd_ready=0 while reset is asserted, then 1 from the first cycle in IDLE. ra=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, stall_cnt=0.
- Reset mid-burst aborts immediately. The buffer empties, in-flight reads are discarded and the state returns to IDLE.
- State machine has three states: IDLE, RUN, DRAIN.
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready. On accept, latch addr=cmd_addr, issue_rem=cmd_len, out_rem=cmd_len.
  - If cmd_len=0, stay in IDLE, pulse done the next cycle and emit no stream words. Otherwise go to RUN.
  - RUN: cmd_ready=0, busy=1. A read is issued in any cycle where credit allows. When issue_rem reaches 0, go to DRAIN.
  - DRAIN: no reads are issued. When the buffer is empty and no read is in flight, go to IDLE with done=1 for exactly one cycle. busy=0 in that cycle.
- Read issue: ra is a registered address counter. Issue in cycle t means ra=addr during cycle t. The block captures q at the end of cycle t+1 into the output buffer.
- After each issue, addr increments modulo 2^AW (511 wraps to 0) and issue_rem decrements.
- Output buffer is a 2-entry FIFO.
- Credit rule: issue only if occupancy + inflight − pop < 2, where pop = out_valid&&out_ready in the same cycle. This guarantees no overflow.
  - With out_ready held high, sustained throughput is one word per cycle.
- Latency: the first out_valid is asserted 3 cycles after the command-accept edge.
- out_data and out_last come from the FIFO head. The FIFO is registered and there is no bypass.
- out_last=1 on the word where out_rem==1 at enqueue. out_rem decrements on each enqueue.
- out_valid, once high, stays high with out_data stable until accepted.
- A command offered while busy is not accepted (cmd_ready=0). The command must be held by the master.
- Memory read-during-write to the same address returns old data. This is the memory's behaviour; the block does not compensate.
- A length of 512 starting at any address reads every word exactly once, wrapping as needed.

Optional Feature:
- Macro: MEM_STREAM_READER_PERF_EN.
- Defined: stall_cnt increments in every cycle where out_valid&&!out_ready. It saturates at 16'hFFFF, clears to 0 on command accept, and holds its value in IDLE.
- Not defined: stall_cnt is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package mem_stream_reader_pkg holds:
  - constants AW=9, DW=20, LW=10;
  - state enum {IDLE, RUN, DRAIN} (logic [1:0]);
  - typedefs addr_t, data_t, len_t.
- One sub-module, fifo2, implements the 2-entry FIFO: push/pop, occupancy, full/empty, with payload {last, data}.

Test Plan:
- Bench preloads mem[i]=20'h0A000+i through the write port. Command addr=5, len=4, out_ready=1 -> words 0x0A005..0x0A008 on consecutive cycles, first word 3 cycles after accept, out_last on 0x0A008, done pulses once.
- Command addr=510, len=4 -> stream 0x0A1FE, 0x0A1FF, 0x0A000, 0x0A001, with address wrap verified on ra.
- addr=0, len=8, out_ready toggled 1,0,0,1,… randomly -> all 8 words in order, no loss or duplication, out_data stable while stalled. With MEM_STREAM_READER_PERF_EN, stall_cnt equals the number of stall cycles.
- cmd_len=0 -> no out_valid, done high exactly one cycle after accept, cmd_ready returns to 1.
- len=512 from addr=100 -> 512 words, last word is 0x0A063, exactly one out_last.
- reset asserted mid-burst (after 3 of 10 words) -> all outputs are at reset values in the same cycle. A new command addr=0, len=2 then returns 0x0A000, 0x0A001 with no stale data.
